id_bypass_stage: RTL

//  Parametrised decode-stage front end for the 5-stage LoongArch pipeline (IF-ID-EX-MA-WB).
//  - Holds the IF->ID pipeline register under the valid/allowin handshake.
//  - Resolves register-source operands by forwarding from NUM_FWD downstream producers

---
 rtl/id_bypass_stage.sv | 80 ++++++++
 1 files changed

// File: rtl/id_bypass_stage.sv
// id_bypass_stage: IF->ID pipeline register with operand forwarding and load-use stall detection
module id_bypass_stage #(
    parameter int BUS_W   = 64,
    parameter int XLEN    = 32,
    parameter int NRS     = 2,
    parameter int NUM_FWD = 3,
    parameter int CNT_W   = 16
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_validout,
    input  logic                    ex_allowin,
    input  logic                    flush,
    input  logic [BUS_W-1:0]        if_to_id_bus,
    output logic                    id_allowin,
    output logic                    id_validout,
    output logic [BUS_W-1:0]        id_bus_q,
    input  logic [NRS-1:0]          rs_en,
    input  logic [NRS*5-1:0]        rs_addr,
    input  logic [NRS*XLEN-1:0]     rf_rdata,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*5-1:0]    fwd_dest,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [NRS*XLEN-1:0]     rs_value,
    output logic [CNT_W-1:0]        stall_cnt,
    input  logic                    stall_clr
);
    logic           valid;
    logic           readygo;
    logic [NRS-1:0] hazard;

    // Pick the youngest matching producer per source; scanning oldest-first lets younger ones override
    always_comb begin
        rs_value = rf_rdata;
        hazard   = '0;
        for (int i = 0; i < NRS; i++) begin
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
                if (rs_en[i] && rs_addr[i*5 +: 5] != 5'd0 && fwd_valid[j] && fwd_we[j] &&
                    fwd_dest[j*5 +: 5] == rs_addr[i*5 +: 5]) begin
                    rs_value[i*XLEN +: XLEN] = fwd_data[j*XLEN +: XLEN];
                    hazard[i] = ~fwd_ready[j];
                end
            end
        end
    end

    assign readygo     = ~(valid & |hazard);
    assign id_allowin  = ~valid | (readygo & ex_allowin);
    assign id_validout = valid & readygo & ~flush;

    // Valid bit: flush kills the held and incoming bundle, otherwise advance on allowin
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= 1'b0;
        else if (flush)
            valid <= 1'b0;
        else if (id_allowin)
            valid <= if_validout;
    end

    // Bus register only captures a bundle that is actually accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            id_bus_q <= '0;
        else if (if_validout & id_allowin & ~flush)
            id_bus_q <= if_to_id_bus;
    end

    // Saturating hazard-stall counter; clear beats increment, flushed cycles are not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (valid & ~readygo & ~flush & ~&stall_cnt)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule
